cpu_datapath: RTL

8-bit accumulator datapath that sits directly downstream of the FSM sequencer and executes its one-hot control strobes. It holds PC, IR, MAR, MDR, ACC and the Z/C flags, drives the single-port memory bus, and returns opcode and flags to the sequencer. Instructions are one byte: opcode in bits [7:4], 4-bit operand/address in [3:0].

---
 rtl/cpu_datapath_pkg.sv | 25 ++
 rtl/cpu_datapath_if.sv | 24 ++
 rtl/cpu_datapath_alu.sv | 68 ++++++
 rtl/cpu_datapath.sv | 124 ++++++++++++
 4 files changed

// File: rtl/cpu_datapath_pkg.sv
// Shared definitions for the accumulator CPU: opcode encodings and
// instruction field positions. The sequencer imports this package too.
package cpu_datapath_pkg;

  localparam int unsigned OPC_W = 4;

  // Instruction field positions at the default 8-bit width
  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 4;
  localparam int unsigned OPD_MSB = 3;
  localparam int unsigned OPD_LSB = 0;

  localparam logic [OPC_W-1:0] OP_ADD   = 4'b0001;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'b0010;
  localparam logic [OPC_W-1:0] OP_AND   = 4'b0011;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'b0100;
  localparam logic [OPC_W-1:0] OP_STORE = 4'b0101;
  localparam logic [OPC_W-1:0] OP_NOT   = 4'b0110;
  localparam logic [OPC_W-1:0] OP_SHL   = 4'b0111;
  localparam logic [OPC_W-1:0] OP_SHR   = 4'b1000;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'b1001;
  localparam logic [OPC_W-1:0] OP_JZ    = 4'b1010;
  localparam logic [OPC_W-1:0] OP_JC    = 4'b1011;

endpackage

// File: rtl/cpu_datapath_if.sv
// Single-port memory bus between the datapath (master) and memory (slave).
// Memory read data is combinational on mem_addr.
interface cpu_datapath_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-5:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/cpu_datapath_alu.sv
// Combinational ALU for the accumulator datapath. result_valid marks opcodes
// that update ACC/Z; carry_valid marks those that also update C.
module cpu_alu
  import cpu_datapath_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [OPC_W-1:0]  op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              carry_out,
  output logic              carry_valid,
  output logic              result_valid
);

  logic [DATA_W:0] wide;

  // Opcode decode and result/carry generation
  always_comb begin
    y            = a;
    carry_out    = 1'b0;
    carry_valid  = 1'b0;
    result_valid = 1'b0;
    wide         = '0;
    case (op)
      OP_ADD: begin
        wide         = {1'b0, a} + {1'b0, b};
        y            = wide[DATA_W-1:0];
        carry_out    = wide[DATA_W];
        carry_valid  = 1'b1;
        result_valid = 1'b1;
      end
      OP_SUB: begin
        // Bit DATA_W of the widened difference is set exactly when a < b
        wide         = {1'b0, a} - {1'b0, b};
        y            = wide[DATA_W-1:0];
        carry_out    = wide[DATA_W];
        carry_valid  = 1'b1;
        result_valid = 1'b1;
      end
      OP_AND: begin
        y            = a & b;
        result_valid = 1'b1;
      end
      OP_NOT: begin
        y            = ~a;
        result_valid = 1'b1;
      end
      OP_SHL: begin
        y            = {a[DATA_W-2:0], 1'b0};
        carry_out    = a[DATA_W-1];
        carry_valid  = 1'b1;
        result_valid = 1'b1;
      end
      OP_SHR: begin
        y            = {1'b0, a[DATA_W-1:1]};
        carry_out    = a[0];
        carry_valid  = 1'b1;
        result_valid = 1'b1;
      end
      default: begin
        y = a;
      end
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// 8-bit accumulator datapath: PC, IR, MAR, MDR, ACC and Z/C flags driven by
// one-hot strobes from the sequencer. Owns the memory bus address/data mux.
module cpu_datapath
  import cpu_datapath_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_inc,
  input  logic                pc_load,
  input  logic                ir_load,
  input  logic                acc_load,
  input  logic                mar_load,
  input  logic                mdr_load,
  input  logic                mem_write,
  cpu_datapath_if.master      mem,
  output logic [OPC_W-1:0]    opcode,
  output logic                zero_flag,
  output logic                carry_flag,
  output logic [DATA_W-5:0]   pc_dbg,
  output logic [DATA_W-1:0]   acc_dbg,
  output logic [DATA_W-1:0]   mdr_dbg
);

  localparam int unsigned ADDR_W = DATA_W - OPC_W;

  logic [ADDR_W-1:0] pc_q,  pc_d;
  logic [DATA_W-1:0] ir_q,  ir_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              z_q,   z_d;
  logic              c_q,   c_d;

  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic              alu_carry;
  logic              alu_carry_valid;
  logic              alu_result_valid;

  assign opcode  = ir_q[DATA_W-1 -: OPC_W];
  assign operand = ir_q[ADDR_W-1:0];
  assign alu_b   = {{OPC_W{1'b0}}, operand};

  cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op           (opcode),
    .a            (acc_q),
    .b            (alu_b),
    .y            (alu_y),
    .carry_out    (alu_carry),
    .carry_valid  (alu_carry_valid),
    .result_valid (alu_result_valid)
  );

  // Memory bus: fetch addresses by PC, everything else by MAR
  assign mem.mem_addr  = ir_load ? pc_q : mar_q;
  assign mem.mem_wdata = acc_q;
  assign mem.mem_we    = mem_write;

  assign zero_flag  = z_q;
  assign carry_flag = c_q;
  assign pc_dbg     = pc_q;
  assign acc_dbg    = acc_q;
  assign mdr_dbg    = mdr_q;

  // Next-state for all registers from the sequencer strobes
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    acc_d = acc_q;
    z_d   = z_q;
    c_d   = c_q;

    if (pc_load) begin
      pc_d = operand;
    end else if (pc_inc) begin
      pc_d = pc_q + 1'b1;
    end

    if (ir_load)  ir_d  = mem.mem_rdata;
    if (mar_load) mar_d = operand;
    if (mdr_load) mdr_d = mem.mem_rdata;

    if (acc_load) begin
      // LOAD takes the bus byte directly so ACC and MDR fill on the same edge
      if (opcode == OP_LOAD) begin
        acc_d = mem.mem_rdata;
        z_d   = (mem.mem_rdata == '0);
      end else if (alu_result_valid) begin
        acc_d = alu_y;
        z_d   = (alu_y == '0);
        if (alu_carry_valid) c_d = alu_carry;
      end
    end
  end

  // Register bank with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      acc_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      acc_q <= acc_d;
      z_q   <= z_d;
      c_q   <= c_d;
    end
  end

endmodule
